// File: rtl/exe_hazard_ctrl.sv
// Execute-stage hazard/forwarding controller for the 5-stage ARM pipeline.
// Optional feature macro: EXE_FWD_EN (defined = operand forwarding, undefined = stall-until-WB).
`timescale 1ns/1ps

module exe_hazard_ctrl #(
  parameter int REG_W = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             id_valid,
  input  logic [REG_W-1:0] id_src1,
  input  logic [REG_W-1:0] id_src2,
  input  logic             id_two_src,
  input  logic [REG_W-1:0] id_dst,
  input  logic             id_wb_en,
  input  logic             id_mem_r_en,
  input  logic             br_taken,
  input  logic             mem_busy,
  output logic             stall,
  output logic             freeze,
  output logic [1:0]       fwd_sel1,
  output logic [1:0]       fwd_sel2,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic {RUN, MEM_WAIT} state_t;

  typedef struct packed {
    logic             v;
    logic             wb;
    logic [REG_W-1:0] dst;
  } slot_t;

  localparam logic [REG_W-1:0] PC_IDX = {REG_W{1'b1}};

  state_t state;
  slot_t  exe_q, mem_q, wb_q;
  logic   exe_ld;

  logic m1_exe, m2_exe, m1_mem, m2_mem;
  logic hazard, enter_v;
  logic [1:0] sel1_d, sel2_d;

  // R15 reads the PC, never a pipeline result.
  function automatic logic match(input logic [REG_W-1:0] src, input slot_t s);
    return s.v & s.wb & (s.dst == src) & (src != PC_IDX);
  endfunction

  always_comb begin
    m1_exe = match(id_src1, exe_q);
    m2_exe = id_two_src & match(id_src2, exe_q);
    m1_mem = match(id_src1, mem_q);
    m2_mem = id_two_src & match(id_src2, mem_q);
  end

  // Reset also drops freeze so every output reads 0 while rst is held.
  assign freeze = mem_busy & ~rst;

`ifdef EXE_FWD_EN
  assign hazard = exe_ld & (m1_exe | m2_exe);
`else
  assign hazard = m1_exe | m2_exe | m1_mem | m2_mem;
`endif

  assign stall   = ~freeze & id_valid & hazard;
  assign enter_v = id_valid & ~stall & ~br_taken;

  always_comb begin
    sel1_d = 2'd0;
    sel2_d = 2'd0;
`ifdef EXE_FWD_EN
    // EXE occupant becomes MEM (alu_result), MEM occupant becomes WB; newest wins.
    if (enter_v) begin
      if (m1_exe && !exe_ld) sel1_d = 2'd1;
      else if (m1_mem)       sel1_d = 2'd2;
      if (m2_exe && !exe_ld) sel2_d = 2'd1;
      else if (m2_mem)       sel2_d = 2'd2;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= RUN;
      exe_q        <= '0;
      mem_q        <= '0;
      wb_q         <= '0;
      exe_ld       <= 1'b0;
      fwd_sel1     <= 2'd0;
      fwd_sel2     <= 2'd0;
      stall_cycles <= '0;
    end else begin
      // NOTE: non-blocking assignments let MEM<=EXE and WB<=MEM shift using pre-edge values.
      state <= mem_busy ? MEM_WAIT : RUN;
      if ((stall || freeze) && stall_cycles != {CNT_W{1'b1}})
        stall_cycles <= stall_cycles + 1'b1;
      if (!freeze) begin
        wb_q     <= mem_q;
        mem_q    <= exe_q;
        exe_q    <= '{v: enter_v, wb: id_wb_en, dst: id_dst};
        exe_ld   <= enter_v & id_mem_r_en;
        fwd_sel1 <= sel1_d;
        fwd_sel2 <= sel2_d;
      end
    end
  end

  // WB occupancy and FSM state are kept for debug visibility only.
  logic unused_dbg;
  assign unused_dbg = ^{wb_q, state, exe_ld};

endmodule

// File: tb/tb_exe_hazard_ctrl.sv
// Scoreboard bench for exe_hazard_ctrl; expectations follow the EXE_FWD_EN build setting.
`timescale 1ns/1ps

module tb_exe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        id_valid = 1'b0;
  logic [3:0]  id_src1 = '0, id_src2 = '0, id_dst = '0;
  logic        id_two_src = 1'b0, id_wb_en = 1'b0, id_mem_r_en = 1'b0;
  logic        br_taken = 1'b0, mem_busy = 1'b0;
  logic        stall, freeze;
  logic [1:0]  fwd_sel1, fwd_sel2;
  logic [15:0] stall_cycles;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct packed {logic [1:0] s1; logic [1:0] s2;} exp_t;
  exp_t exp_q[$];

  exe_hazard_ctrl #(.REG_W(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_src1(id_src1), .id_src2(id_src2),
    .id_two_src(id_two_src), .id_dst(id_dst), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .br_taken(br_taken), .mem_busy(mem_busy), .stall(stall), .freeze(freeze),
    .fwd_sel1(fwd_sel1), .fwd_sel2(fwd_sel2), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

  // Scoreboard: one expected select pair is pushed before an edge, popped 1 ns after it.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      n_chk++;
      if (fwd_sel1 !== e.s1 || fwd_sel2 !== e.s2) begin
        n_fail++;
        $display("FAIL fwd_sel @%0t: got sel1=%0d sel2=%0d expected sel1=%0d sel2=%0d",
                 $time, fwd_sel1, fwd_sel2, e.s1, e.s2);
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] s1, input logic [3:0] s2,
                       input logic two, input logic [3:0] d, input logic wb, input logic ld);
    id_valid = v; id_src1 = s1; id_src2 = s2; id_two_src = two;
    id_dst = d; id_wb_en = wb; id_mem_r_en = ld;
  endtask

  task automatic idle();
    drive(1'b0, 4'd0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] e1, input logic [1:0] e2);
    exp_q.push_back('{s1: e1, s2: e2});
  endtask

  task automatic do_reset();
    idle(); br_taken = 1'b0; mem_busy = 1'b0;
    rst = 1'b1; #1; rst = 1'b0; #1;
  endtask

  task automatic chk_stall(input string tag, input logic exp);
    n_chk++;
    if (stall !== exp) begin
      n_fail++; $display("FAIL %s: stall=%0b expected %0b", tag, stall, exp);
    end
  endtask

  task automatic chk_cnt(input string tag, input logic [15:0] exp);
    n_chk++;
    if (stall_cycles !== exp) begin
      n_fail++; $display("FAIL %s: stall_cycles=%0h expected %0h", tag, stall_cycles, exp);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; mem_busy = 1'b1; idle();
    #2;
    n_chk++;
    if (stall !== 1'b0 || freeze !== 1'b0 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 ||
        stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_state: stall=%0b freeze=%0b sel1=%0d sel2=%0d cnt=%0h expected all 0",
               stall, freeze, fwd_sel1, fwd_sel2, stall_cycles);
    end
    mem_busy = 1'b0; #1; rst = 1'b0;
    tick();
  endtask

  task automatic test_fwd_b2b();
    do_reset();
    drive(1, 4'd8, 4'd9, 1, 4'd1, 1, 0); #1;     // ADD R1,R8,R9
    chk_stall("b2b_producer", 1'b0); push(0, 0); tick();
    drive(1, 4'd1, 4'd3, 1, 4'd2, 1, 0); #1;     // ADD R2,R1,R3
`ifdef EXE_FWD_EN
    chk_stall("b2b_consumer", 1'b0); push(1, 0); tick();
    idle(); chk_cnt("b2b_cnt", 16'd0);
`else
    chk_stall("b2b_stall_1", 1'b1); push(0, 0); tick(); #1;
    chk_stall("b2b_stall_2", 1'b1); push(0, 0); tick(); #1;
    chk_stall("b2b_release", 1'b0); push(0, 0); tick();
    idle(); chk_cnt("b2b_cnt", 16'd2);
`endif
  endtask

  task automatic test_load_use();
    do_reset();
    drive(1, 4'd10, 4'd0, 0, 4'd4, 1, 1); #1;    // LDR R4,[R10]
    push(0, 0); tick();
    drive(1, 4'd4, 4'd0, 0, 4'd5, 1, 0); #1;     // SUB R5,R4,#1
    chk_stall("ld_use_stall", 1'b1); push(0, 0); tick(); #1;
`ifdef EXE_FWD_EN
    chk_stall("ld_use_release", 1'b0); push(2, 0); tick();
    idle(); chk_cnt("ld_use_cnt", 16'd1);
`else
    chk_stall("ld_use_stall_2", 1'b1); push(0, 0); tick(); #1;
    chk_stall("ld_use_release", 1'b0); push(0, 0); tick();
    idle(); chk_cnt("ld_use_cnt", 16'd2);
`endif
  endtask

  task automatic test_newest_wins();
    do_reset();
    drive(1, 4'd12, 4'd0, 0, 4'd6, 1, 0); #1; push(0, 0); tick();   // MOV R6
    drive(1, 4'd12, 4'd0, 0, 4'd6, 1, 0); #1; push(0, 0); tick();   // MOV R6
    drive(1, 4'd6, 4'd6, 1, 4'd7, 1, 0); #1;                        // ADD R7,R6,R6
`ifdef EXE_FWD_EN
    chk_stall("newest_no_stall", 1'b0); push(1, 1); tick();
`else
    chk_stall("newest_stall_1", 1'b1); push(0, 0); tick(); #1;
    chk_stall("newest_stall_2", 1'b1); push(0, 0); tick(); #1;
    chk_stall("newest_release", 1'b0); push(0, 0); tick();
`endif
    idle();
  endtask

  task automatic test_no_match();
    do_reset();
    drive(1, 4'd8, 4'd9, 1, 4'd1, 0, 0); #1; push(0, 0); tick();    // CMP (no writeback)
    drive(1, 4'd1, 4'd9, 1, 4'd2, 1, 0); #1;                        // ADD R2,R1,R9
    chk_stall("cmp_no_stall", 1'b0); push(0, 0); tick();
    drive(1, 4'd8, 4'd0, 0, 4'd15, 1, 0); #1;                       // MOV R15
    chk_stall("r15_producer", 1'b0); push(0, 0); tick();
    drive(1, 4'd15, 4'd0, 0, 4'd3, 1, 0); #1;                       // reads R15
    chk_stall("r15_consumer", 1'b0); push(0, 0); tick();
    drive(1, 4'd12, 4'd3, 0, 4'd4, 1, 0); #1;                       // src2=R3 not read
    chk_stall("src2_unchecked", 1'b0); push(0, 0); tick();
    idle();
  endtask

  task automatic test_freeze();
    do_reset();
    drive(1, 4'd13, 4'd0, 0, 4'd4, 1, 1); #1; push(0, 0); tick();   // LDR R4
    drive(1, 4'd4, 4'd0, 0, 4'd5, 1, 0);                            // SUB R5,R4
    mem_busy = 1'b1; br_taken = 1'b1; #1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if (freeze !== 1'b1) begin
        n_fail++; $display("FAIL freeze_hold[%0d]: freeze=%0b expected 1", i, freeze);
      end
      chk_stall("freeze_forces_stall_0", 1'b0);
      push(0, 0); tick(); #1;
    end
    mem_busy = 1'b0; br_taken = 1'b0; #1;
    chk_stall("post_freeze_stall", 1'b1); push(0, 0); tick(); #1;
`ifdef EXE_FWD_EN
    chk_stall("post_freeze_release", 1'b0); push(2, 0); tick();
    idle(); chk_cnt("freeze_cnt", 16'd4);
`else
    chk_stall("post_freeze_stall_2", 1'b1); push(0, 0); tick(); #1;
    chk_stall("post_freeze_release", 1'b0); push(0, 0); tick();
    idle(); chk_cnt("freeze_cnt", 16'd5);
`endif
  endtask

  task automatic test_branch();
    do_reset();
    drive(1, 4'd8, 4'd9, 1, 4'd1, 1, 0); #1; push(0, 0); tick();    // ADD R1
    drive(1, 4'd1, 4'd3, 1, 4'd2, 1, 0); br_taken = 1'b1; #1;       // ADD R2,R1 flushed
`ifdef EXE_FWD_EN
    chk_stall("branch_stall", 1'b0);
`else
    chk_stall("branch_stall", 1'b1);
`endif
    push(0, 0); tick();
    br_taken = 1'b0;
    drive(1, 4'd2, 4'd0, 0, 4'd3, 1, 0); #1;                        // reads flushed R2
    chk_stall("after_flush_no_stall", 1'b0); push(0, 0); tick();
    idle();
  endtask

  task automatic test_reset_mid_freeze();
    do_reset();
    drive(1, 4'd8, 4'd9, 1, 4'd1, 1, 0); #1; push(0, 0); tick();
    drive(1, 4'd1, 4'd3, 1, 4'd2, 1, 0); #1;
`ifdef EXE_FWD_EN
    push(1, 0);
`endif
    tick();
    idle(); mem_busy = 1'b1; #1;
    tick(); tick(); #1;
    rst = 1'b1; #1;
    n_chk++;
    if (stall !== 1'b0 || freeze !== 1'b0 || fwd_sel1 !== 2'd0 || fwd_sel2 !== 2'd0 ||
        stall_cycles !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_freeze: stall=%0b freeze=%0b sel1=%0d sel2=%0d cnt=%0h expected all 0",
               stall, freeze, fwd_sel1, fwd_sel2, stall_cycles);
    end
    mem_busy = 1'b0; #1; rst = 1'b0;
    tick();
  endtask

  task automatic test_saturate();
    do_reset();
    mem_busy = 1'b1;
    repeat (65534) tick();
    chk_cnt("cnt_before_sat", 16'hFFFE);
    tick();
    chk_cnt("cnt_at_sat", 16'hFFFF);
    repeat (3) tick();
    chk_cnt("cnt_held_sat", 16'hFFFF);
    mem_busy = 1'b0;
    tick();
  endtask

  initial begin
    test_reset();
    test_fwd_b2b();
    test_load_use();
    test_newest_wins();
    test_no_match();
    test_freeze();
    test_branch();
    test_reset_mid_freeze();
    test_saturate();
    #20;
    n_chk++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
